// File: rtl/dma_pkg.sv
// Shared definitions for the word-copy DMA engine: FSM states and bus constants.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

  localparam logic [3:0]  MEM_BE_ALL = 4'b1111;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // A byte address is word aligned when its two low bits are clear.
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dma_copy.sv
// Word-copy DMA engine: copies len 32-bit words from src_addr to dst_addr
// in ascending order over a single-port RAM with a one-cycle registered read.
// Each word costs one READ cycle followed by one WRITE cycle.
module dma_copy
  import dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  dma_state_t       state;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [LEN_W-1:0] count;

  // Transfer sequencer: accepts or rejects commands, walks the pointers and
  // produces the registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!is_aligned(src_addr) || !is_aligned(dst_addr)) begin
              err <= 1'b1;
            end else if (len == '0) begin
              state <= DONE;
              busy  <= 1'b1;
              done  <= 1'b1;
            end else begin
              src_ptr <= src_addr;
              dst_ptr <= dst_addr;
              count   <= len;
              state   <= READ;
              busy    <= 1'b1;
            end
          end
        end
        READ: begin
          state <= WRITE;
        end
        WRITE: begin
          src_ptr <= src_ptr + WORD_BYTES;
          dst_ptr <= dst_ptr + WORD_BYTES;
          count   <= count - LEN_W'(1);
          if (count == LEN_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= READ;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Memory port decode from the registered state; write data is the RAM read
  // data passed straight through so each word moves in two cycles.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      READ: begin
        mem_req  = 1'b1;
        mem_addr = src_ptr;
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_be    = MEM_BE_ALL;
        mem_addr  = dst_ptr;
        mem_wdata = mem_rdata;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dma_copy.sv
// Self-checking bench for dma_copy: directed scenarios plus randomized copies
// compared against an address-level reference of what the memory should hold.
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram     [0:1023];
  logic [31:0] initRam [0:1023];
  logic [31:0] expRam  [0:1023];
  logic        loadRam;

  logic [36:0] trace [0:4095];
  int          traceCnt = 0;

  always #5 clk = ~clk;

  dma_copy #(.LEN_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Single-port RAM with one-cycle registered read, 4 KB window aliased by address.
  always @(posedge clk) begin
    if (loadRam) begin
      for (int i = 0; i < 1024; i++) ram[i] <= initRam[i];
    end else if (mem_req && mem_we) begin
      ram[mem_addr[11:2]] <= mem_wdata;
    end
    if (mem_req && !mem_we) mem_rdata <= ram[mem_addr[11:2]];
  end

  // Bus monitor: logs every memory access as {we, be, addr}.
  always @(posedge clk) begin
    if (mem_req) begin
      trace[traceCnt % 4096] <= {mem_we, mem_be, mem_addr};
      traceCnt <= traceCnt + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic loadMemory();
    for (int i = 0; i < 1024; i++) initRam[i] = $urandom;
    loadRam = 1'b1;
    @(posedge clk); #1;
    loadRam = 1'b0;
  endtask

  task automatic compareMemory(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== expRam[i]) bad++;
    checkOutput(tag, 32'(bad), 32'd0);
  endtask

  // Run one accepted copy and check timing, bus trace and resulting memory.
  task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n, input bit midStart);
    int base, cycles, bad, nw;
    bit busyOk;
    logic [31:0] sa, da;
    logic [36:0] er, ew;
    nw = int'(n);
    for (int i = 0; i < 1024; i++) expRam[i] = initRam[i];
    for (int i = 0; i < nw; i++) begin
      sa = s + 32'(i) * 32'd4;
      da = d + 32'(i) * 32'd4;
      expRam[da[11:2]] = expRam[sa[11:2]];
    end
    base = traceCnt;
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    busyOk = 1'b1;
    while (!done && cycles < 4 * nw + 10) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      if (midStart && cycles == 2) begin
        src_addr = 32'h10; dst_addr = 32'h20; len = 16'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    checkOutput("doneLatency", 32'(cycles), 32'(2 * nw + 1));
    checkOutput("busyInDone", 32'(busy), 32'd1);
    checkOutput("memReqInDone", 32'(mem_req), 32'd0);
    checkOutput("busyDuring", 32'(busyOk), 32'd1);
    @(posedge clk); #1;
    checkOutput("flagsAfterDone", 32'({busy, done, err}), 32'd0);
    checkOutput("idleBus", 32'(mem_req | mem_we | (|mem_be) | (|mem_addr) | (|mem_wdata)), 32'd0);
    checkOutput("traceLen", 32'(traceCnt - base), 32'(2 * nw));
    bad = 0;
    for (int i = 0; i < nw; i++) begin
      er = {1'b0, 4'b0000, s + 32'(i) * 32'd4};
      ew = {1'b1, 4'b1111, d + 32'(i) * 32'd4};
      if (trace[(base + 2 * i) % 4096] !== er) bad++;
      if (trace[(base + 2 * i + 1) % 4096] !== ew) bad++;
    end
    checkOutput("traceOrder", 32'(bad), 32'd0);
    compareMemory("memWords");
  endtask

  // Issue a start that must be rejected and verify nothing moved.
  task automatic applyReject(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    int base;
    for (int i = 0; i < 1024; i++) expRam[i] = initRam[i];
    base = traceCnt;
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("errPulse", 32'(err), 32'd1);
    checkOutput("busyOnReject", 32'(busy), 32'd0);
    @(posedge clk); #1;
    checkOutput("errCleared", 32'(err), 32'd0);
    checkOutput("busyAfterReject", 32'(busy), 32'd0);
    checkOutput("rejectNoAccess", 32'(traceCnt - base), 32'd0);
    compareMemory("rejectMem");
  endtask

  initial begin
    int base;
    bit sawDone;
    logic [31:0] s, d;
    logic [15:0] n;
    rst = 1'b1; start = 1'b0; loadRam = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetFlags", 32'({busy, done, err}), 32'd0);
    checkOutput("resetBus", 32'(mem_req | mem_we | (|mem_be) | (|mem_addr) | (|mem_wdata)), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic four-word copy");
    for (int i = 0; i < 1024; i++) initRam[i] = $urandom;
    initRam[32'h100 >> 2] = 32'd11; initRam[32'h104 >> 2] = 32'd22;
    initRam[32'h108 >> 2] = 32'd33; initRam[32'h10C >> 2] = 32'd44;
    loadRam = 1'b1; @(posedge clk); #1; loadRam = 1'b0;
    applyStimulus(32'h100, 32'h200, 16'd4, 1'b0);
    checkOutput("dst200", ram[32'h200 >> 2], 32'd11);
    checkOutput("dst20C", ram[32'h20C >> 2], 32'd44);

    $display("[TB] zero-length copy");
    loadMemory();
    applyStimulus(32'h100, 32'h200, 16'd0, 1'b0);

    $display("[TB] misaligned starts");
    applyReject(32'h102, 32'h200, 16'd4);
    applyReject(32'h100, 32'h203, 16'd4);

    $display("[TB] wrap-around with ignored mid-copy start");
    loadMemory();
    applyStimulus(32'hFFFF_FFFC, 32'h500, 16'd2, 1'b1);

    $display("[TB] overlapping and identical regions");
    loadMemory();
    applyStimulus(32'h100, 32'h104, 16'd3, 1'b0);
    checkOutput("overlapFwd", ram[32'h10C >> 2], initRam[32'h100 >> 2]);
    loadMemory();
    applyStimulus(32'h300, 32'h300, 16'd3, 1'b0);

    $display("[TB] reset in the middle of a copy");
    loadMemory();
    base = traceCnt;
    src_addr = 32'h300; dst_addr = 32'h600; len = 16'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abortFlags", 32'({busy, done, err}), 32'd0);
    checkOutput("abortBus", 32'(mem_req | mem_we | (|mem_be) | (|mem_addr) | (|mem_wdata)), 32'd0);
    rst = 1'b0;
    sawDone = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("abortNoDone", 32'(sawDone), 32'd0);
    checkOutput("abortAccesses", 32'(traceCnt - base), 32'd2);
    for (int i = 0; i < 1024; i++) expRam[i] = initRam[i];
    expRam[32'h600 >> 2] = initRam[32'h300 >> 2];
    compareMemory("abortMem");

    $display("[TB] randomized copies");
    for (int t = 0; t < 25; t++) begin
      loadMemory();
      s = 32'($urandom_range(0, 1023)) << 2;
      d = ($urandom_range(0, 3) == 0) ? s : (32'($urandom_range(0, 1023)) << 2);
      n = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) s = s | 32'($urandom_range(1, 3));
        else d = d | 32'($urandom_range(1, 3));
        applyReject(s, d, n);
      end else begin
        applyStimulus(s, d, n, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
